decode_cycle: RTL

//  Second stage of the 5-stage RV32I pipeline: consumes the IF/ID register (InstrD, PCD, PCPlus4D).

---
 rtl/decode_cycle_if.sv | 36 +++
 rtl/decode_cycle.sv | 115 +++++++++++
 2 files changed

// File: rtl/decode_cycle_if.sv
// decode_cycle_if: IF/ID inputs, writeback port and ID/EX outputs of the decode stage
interface decode_cycle_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic        IllegalE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    modport master (
        output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, IllegalE,
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );
    modport slave (
        input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, IllegalE,
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file and ID/EX pipeline register
module decode_cycle (
    input logic clk,
    input logic rst,
    decode_cycle_if.slave bus
);
    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic        illegal;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } id_ex_t;
    logic [31:0] regs [32];
    logic [31:0] instr, rd1, rd2, imm_i, imm_s, imm_b, imm_j;
    logic [6:0]  op, f7;
    logic [4:0]  a1, a2;
    logic [2:0]  f3, alu_code;
    logic        f3_ok;
    id_ex_t      d, q;
    assign instr = bus.InstrD;
    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign a1 = instr[19:15];
    assign a2 = instr[24:20];
    // Writeback bypass: a register written this cycle reads as the new value
    assign rd1 = a1 == 5'd0 ? '0 : bus.RegWriteW && bus.RdW == a1 ? bus.ResultW : regs[a1];
    assign rd2 = a2 == 5'd0 ? '0 : bus.RegWriteW && bus.RdW == a2 ? bus.ResultW : regs[a2];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign alu_code = f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 : f3 == 3'b010 ? 3'b101 : 3'b000;
    assign f3_ok = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010;
    always_comb begin
        d = '0;
        d.rd1 = rd1;
        d.rd2 = rd2;
        d.pc = bus.PCD;
        d.pc_plus4 = bus.PCPlus4D;
        d.rs1 = a1;
        d.rs2 = a2;
        d.rd = instr[11:7];
        d.imm = op == 7'b0100011 ? imm_s : op == 7'b1100011 ? imm_b : op == 7'b1101111 ? imm_j : imm_i;
        case (op)
            7'b0110011: begin
                d.illegal = !((f7 == 7'h00 && f3_ok) || (f7 == 7'h20 && f3 == 3'b000));
                d.reg_write = !d.illegal;
                d.alu_control = d.illegal ? 3'b000 : f7[5] ? 3'b001 : alu_code;
            end
            7'b0010011: begin
                d.illegal = !f3_ok;
                d.reg_write = f3_ok;
                d.alu_src = f3_ok;
                d.alu_control = f3_ok ? alu_code : 3'b000;
            end
            7'b0000011: begin
                d.illegal = f3 != 3'b010;
                d.reg_write = !d.illegal;
                d.alu_src = !d.illegal;
                d.result_src = d.illegal ? 2'b00 : 2'b01;
            end
            7'b0100011: begin
                d.illegal = f3 != 3'b010;
                d.mem_write = !d.illegal;
                d.alu_src = !d.illegal;
            end
            7'b1100011: begin
                d.illegal = f3 != 3'b000;
                d.branch = !d.illegal;
                d.alu_control = d.illegal ? 3'b000 : 3'b001;
            end
            7'b1101111: begin
                d.jump = 1'b1;
                d.reg_write = 1'b1;
                d.result_src = 2'b10;
            end
            default: d.illegal = 1'b1;
        endcase
    end
    always_ff @(posedge clk)
        if (!rst || bus.FlushE) q <= '0;
        else q <= d;
    always_ff @(posedge clk)
        if (!rst) regs <= '{default: '0};
        else if (bus.RegWriteW && bus.RdW != 5'd0) regs[bus.RdW] <= bus.ResultW;
    assign bus.RegWriteE = q.reg_write;
    assign bus.ResultSrcE = q.result_src;
    assign bus.MemWriteE = q.mem_write;
    assign bus.JumpE = q.jump;
    assign bus.BranchE = q.branch;
    assign bus.ALUControlE = q.alu_control;
    assign bus.ALUSrcE = q.alu_src;
    assign bus.IllegalE = q.illegal;
    assign bus.RD1E = q.rd1;
    assign bus.RD2E = q.rd2;
    assign bus.ImmExtE = q.imm;
    assign bus.PCE = q.pc;
    assign bus.PCPlus4E = q.pc_plus4;
    assign bus.Rs1E = q.rs1;
    assign bus.Rs2E = q.rs2;
    assign bus.RdE = q.rd;
endmodule
